// File: rtl/life_pkg.sv
// Shared types and grid geometry for the Game-of-Life generation scheduler.
// Grid is X_SIZE x Y_SIZE cells held in two ping-pong BRAM banks.
package life_pkg;

  localparam int X_SIZE       = 1280;
  localparam int Y_SIZE       = 720;
  localparam int Y_WIDTH      = $clog2(Y_SIZE);
  localparam int MAX_INFLIGHT = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    WAIT_SWAP
  } state_e;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/life_gen_scheduler_if.sv
// Row request handshake to the line buffer plus the row write-back strobe
// returned by the next-state stage.
interface life_gen_scheduler_if #(
  parameter int Y_WIDTH = life_pkg::Y_WIDTH
) ();

  logic               row_req_valid;
  logic               row_req_ready;
  logic [Y_WIDTH-1:0] row_req_addr;
  logic               row_wr_en;

  modport master (
    output row_req_valid,
    output row_req_addr,
    input  row_req_ready,
    input  row_wr_en
  );

  modport slave (
    input  row_req_valid,
    input  row_req_addr,
    output row_req_ready,
    output row_wr_en
  );

endinterface

// File: rtl/row_issue_tracker.sv
// Counts rows issued, rows written back and rows in flight for one generation.
// A write-back with nothing in flight only raises the sticky err flag.
module row_issue_tracker
  import life_pkg::*;
#(
  parameter int Y_SIZE       = life_pkg::Y_SIZE,
  parameter int Y_WIDTH      = life_pkg::Y_WIDTH,
  parameter int MAX_INFLIGHT = life_pkg::MAX_INFLIGHT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               issue,
  input  logic               wb,
  output logic [Y_WIDTH-1:0] issued_addr,
  output logic               all_issued,
  output logic               all_written,
  output logic               credit_ok,
  output logic               err
);

  localparam int CW = Y_WIDTH + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] written_q, written_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          wb_ok;

  always_comb begin
    issued_d   = issued_q;
    written_d  = written_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    wb_ok      = wb && (inflight_q != '0);
    if (wb && !wb_ok) begin
      err_d = 1'b1;
    end
    if (start) begin
      issued_d   = '0;
      written_d  = '0;
      inflight_d = '0;
    end else begin
      if (issue) begin
        issued_d = issued_q + CW'(1);
      end
      if (wb_ok) begin
        written_d = written_q + CW'(1);
      end
      // simultaneous issue and write-back cancel out
      case ({issue, wb_ok})
        2'b10:   inflight_d = inflight_q + IW'(1);
        2'b01:   inflight_d = inflight_q - IW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q   <= '0;
      written_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      issued_q   <= issued_d;
      written_q  <= written_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign issued_addr = issued_q[Y_WIDTH-1:0];
  assign all_issued  = (issued_q == CW'(Y_SIZE));
  assign all_written = (written_d == CW'(Y_SIZE));
  assign credit_ok   = (inflight_q < IW'(MAX_INFLIGHT));
  assign err         = err_q;

endmodule

// File: rtl/life_gen_scheduler.sv
// Game-of-Life generation sequencer: host load, row issue, frame-synced bank swap.
// Define LIFE_GEN_COUNT_EN to build the generation counter; otherwise gen_count is 0.
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int Y_SIZE       = life_pkg::Y_SIZE,
  parameter int Y_WIDTH      = life_pkg::Y_WIDTH,
  parameter int MAX_INFLIGHT = life_pkg::MAX_INFLIGHT
) (
  input  logic                 out_stream_aclk,
  input  logic                 periph_reset,
  input  logic                 load_start,
  input  logic                 load_row_valid,
  output logic                 load_row_ack,
  output logic                 load_wr_en,
  output logic [Y_WIDTH-1:0]   load_wr_addr,
  input  logic                 pause,
  input  logic                 step,
  input  logic                 frame_end,
  life_gen_scheduler_if.master rq,
  output logic                 bank_disp,
  output logic                 bank_wr,
  output logic                 busy,
  output logic                 gen_done,
  output logic                 err,
  output logic [31:0]          gen_count
);

  state_e             state_q, state_d;
  logic               bank_q, bank_d;
  logic               loaded_q, loaded_d;
  logic               pend_q, pend_d;
  logic               from_comp_q, from_comp_d;
  logic               gen_done_q, gen_done_d;
  logic [Y_WIDTH-1:0] ptr_q, ptr_d;

  logic               start;
  logic               ack;
  logic               req_valid;
  logic               issue;
  logic [Y_WIDTH-1:0] issued_addr;
  logic               all_issued;
  logic               all_written;
  logic               credit_ok;

  assign req_valid = (state_q == COMPUTE) && !all_issued && credit_ok;
  assign issue     = req_valid && rq.row_req_ready;

  row_issue_tracker #(
    .Y_SIZE       (Y_SIZE),
    .Y_WIDTH      (Y_WIDTH),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_tracker (
    .clk         (out_stream_aclk),
    .rst         (periph_reset),
    .start       (start),
    .issue       (issue),
    .wb          (rq.row_wr_en),
    .issued_addr (issued_addr),
    .all_issued  (all_issued),
    .all_written (all_written),
    .credit_ok   (credit_ok),
    .err         (err)
  );

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    loaded_d    = loaded_q;
    pend_d      = pend_q;
    from_comp_d = from_comp_q;
    gen_done_d  = 1'b0;
    ptr_d       = ptr_q;
    start       = 1'b0;
    ack         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q || load_start) begin
          state_d = LOAD;
          pend_d  = 1'b0;
          ptr_d   = '0;
        end else if (loaded_q && (!pause || step)) begin
          state_d = COMPUTE;
          start   = 1'b1;
        end
      end
      LOAD: begin
        if (load_row_valid) begin
          ack   = 1'b1;
          ptr_d = ptr_q + Y_WIDTH'(1);
          if (ptr_q == Y_WIDTH'(Y_SIZE - 1)) begin
            loaded_d    = 1'b1;
            from_comp_d = 1'b0;
            state_d     = WAIT_SWAP;
          end
        end
      end
      COMPUTE: begin
        if (all_written) begin
          from_comp_d = 1'b1;
          state_d     = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        // swap only on a frame boundary so scan-out never tears
        if (frame_end) begin
          bank_d     = ~bank_q;
          gen_done_d = from_comp_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && load_start) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state_q     <= IDLE;
      bank_q      <= BANK_A;
      loaded_q    <= 1'b0;
      pend_q      <= 1'b0;
      from_comp_q <= 1'b0;
      gen_done_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      loaded_q    <= loaded_d;
      pend_q      <= pend_d;
      from_comp_q <= from_comp_d;
      gen_done_q  <= gen_done_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef LIFE_GEN_COUNT_EN
  logic [31:0] gen_cnt_q, gen_cnt_d;

  always_comb begin
    gen_cnt_d = gen_cnt_q;
    if (gen_done_d) begin
      gen_cnt_d = gen_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      gen_cnt_q <= '0;
    end else begin
      gen_cnt_q <= gen_cnt_d;
    end
  end

  assign gen_count = gen_cnt_q;
`else
  assign gen_count = 32'd0;
`endif

  assign rq.row_req_valid = req_valid;
  assign rq.row_req_addr  = issued_addr;
  assign load_row_ack     = ack;
  assign load_wr_en       = ack;
  assign load_wr_addr     = ptr_q;
  assign bank_disp        = bank_q;
  assign bank_wr          = ~bank_q;
  assign busy             = (state_q != IDLE);
  assign gen_done         = gen_done_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Self-checking bench for life_gen_scheduler: directed scenarios with a
// behavioural model compared every cycle on the falling clock edge.
module tb_life_gen_scheduler;

  localparam int YS = 720;
  localparam int MI = 4;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_COMP = 2;
  localparam int M_WAIT = 3;
`ifdef LIFE_GEN_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_row_valid = 1'b0;
  logic        load_row_ack;
  logic        load_wr_en;
  logic [9:0]  load_wr_addr;
  logic        pause = 1'b1;
  logic        step = 1'b0;
  logic        frame_end = 1'b0;
  logic        bank_disp;
  logic        bank_wr;
  logic        busy;
  logic        gen_done;
  logic        err;
  logic [31:0] gen_count;

  logic auto_wb = 1'b0;
  logic manual_wb = 1'b0;
  logic rnd_bit = 1'b0;
  logic rand_ready = 1'b0;
  logic ready_lvl = 1'b0;
  int   wb_delay = 3;
  int   cyc_n = 0;
  int   wq[$];

  life_gen_scheduler_if rq_if ();

  assign rq_if.row_wr_en     = auto_wb | manual_wb;
  assign rq_if.row_req_ready = rand_ready ? rnd_bit : ready_lvl;

  life_gen_scheduler dut (
    .out_stream_aclk (clk),
    .periph_reset    (rst),
    .load_start      (load_start),
    .load_row_valid  (load_row_valid),
    .load_row_ack    (load_row_ack),
    .load_wr_en      (load_wr_en),
    .load_wr_addr    (load_wr_addr),
    .pause           (pause),
    .step            (step),
    .frame_end       (frame_end),
    .rq              (rq_if),
    .bank_disp       (bank_disp),
    .bank_wr         (bank_wr),
    .busy            (busy),
    .gen_done        (gen_done),
    .err             (err),
    .gen_count       (gen_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // model state
  bit          mv = 1'b0;
  int          m_mode, m_ptr, m_issued, m_written, m_infl;
  bit          m_disp, m_loaded, m_pend, m_err, m_gdone, m_fromc;
  int unsigned m_gen;
  int          infl_max = 0;
  int          coinc = 0;
  int          wr720 = 0;
  int          ack_cnt = 0;
  int          gd_cnt = 0;
  int          issue_cnt = 0;

  function automatic bit m_req_valid();
    return (m_mode == M_COMP) && (m_issued < YS) && (m_infl < MI);
  endfunction

  task automatic model_step();
    int  old;
    bit  iss;
    bit  wb;
    if (rst) begin
      m_mode = M_IDLE; m_disp = 0; m_loaded = 0; m_pend = 0;
      m_ptr = 0; m_issued = 0; m_written = 0; m_infl = 0;
      m_err = 0; m_gen = 0; m_gdone = 0; m_fromc = 0;
      mv = 1'b1;
      return;
    end
    old = m_mode;
    iss = m_req_valid() && rq_if.row_req_ready;
    wb  = rq_if.row_wr_en;
    m_gdone = 0;
    if (iss && wb && m_infl > 0) coinc++;
    if (wb) begin
      if (m_infl == 0) m_err = 1;
      else begin
        m_infl--;
        m_written++;
      end
    end
    if (iss) begin
      m_issued++;
      m_infl++;
    end
    if (m_infl > infl_max) infl_max = m_infl;
    case (old)
      M_IDLE: begin
        if (m_pend || load_start) begin
          m_mode = M_LOAD; m_pend = 0; m_ptr = 0;
        end else if (m_loaded && (!pause || step)) begin
          m_mode = M_COMP; m_issued = 0; m_written = 0; m_infl = 0;
        end
      end
      M_LOAD: begin
        if (load_row_valid) begin
          if (m_ptr == YS - 1) begin
            m_loaded = 1; m_fromc = 0; m_mode = M_WAIT;
          end
          m_ptr++;
        end
      end
      M_COMP: begin
        if (m_written == YS) begin
          m_mode = M_WAIT; m_fromc = 1; wr720++;
        end
      end
      default: begin
        if (frame_end) begin
          m_disp = !m_disp;
          m_mode = M_IDLE;
          if (m_fromc) begin
            m_gdone = 1;
            m_gen++;
          end
        end
      end
    endcase
    if (old != M_IDLE && load_start) m_pend = 1;
  endtask

  always @(negedge clk) begin
    bit ev, ea;
    if (mv) begin
      ev = m_req_valid();
      ea = (m_mode == M_LOAD) && load_row_valid;
      chk("row_req_valid", rq_if.row_req_valid, ev);
      if (ev) chk("row_req_addr", rq_if.row_req_addr, m_issued);
      chk("load_row_ack", load_row_ack, ea);
      chk("load_wr_en", load_wr_en, ea);
      if (ea) chk("load_wr_addr", load_wr_addr, m_ptr);
      chk("bank_disp", bank_disp, m_disp);
      chk("bank_wr", bank_wr, !m_disp);
      chk("busy", busy, m_mode != M_IDLE);
      chk("gen_done", gen_done, m_gdone);
      chk("err", err, m_err);
      chk("gen_count", gen_count, CNT_EN ? m_gen : 0);
      if (load_row_ack === 1'b1) ack_cnt++;
      if (gen_done === 1'b1) gd_cnt++;
      if (rq_if.row_req_valid === 1'b1 && rq_if.row_req_ready === 1'b1) begin
        issue_cnt++;
        if (!rst) wq.push_back(cyc_n + wb_delay);
      end
    end
    if (rst) wq.delete();
    model_step();
  end

  // line buffer / next-state stage stand-in
  always @(posedge clk) begin
    cyc_n++;
    #1;
    if (wq.size() > 0 && wq[0] <= cyc_n) begin
      void'(wq.pop_front());
      auto_wb = 1'b1;
    end else begin
      auto_wb = 1'b0;
    end
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_mode(int m, int budget);
    int n = 0;
    while (m_mode != m && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_mode", m_mode, m);
  endtask

  task automatic pulse_frame();
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
  endtask

  task automatic load_grid(int target);
    int n = 0;
    load_row_valid = 1'b1;
    while (ack_cnt < target && n < 3000) begin
      cyc(1);
      n++;
    end
    load_row_valid = 1'b0;
    chk("load_acks", ack_cnt, target);
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_bank", bank_disp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gen_count", gen_count, 0);

    // host load, swap at first frame_end
    load_start = 1'b1;
    load_row_valid = 1'b1;
    cyc(1);
    load_start = 1'b0;
    load_grid(720);
    cyc(5);
    chk("t1_wait_busy", busy, 1);
    chk("t1_bank_before", bank_disp, 0);
    pulse_frame();
    chk("t1_bank_after", bank_disp, 1);
    cyc(2);
    chk("t1_no_gen_done", gd_cnt, 0);

    // one generation, write-back 3 cycles after issue
    wb_delay = 3;
    ready_lvl = 1'b1;
    pause = 1'b0;
    cyc(2);
    pause = 1'b1;
    wait_mode(M_WAIT, 3000);
    cyc(10);
    chk("t2_gd_before_frame", gd_cnt, 0);
    chk("t2_bank_before", bank_disp, 1);
    pulse_frame();
    cyc(2);
    chk("t2_gd", gd_cnt, 1);
    chk("t2_bank", bank_disp, 0);
    chk("t2_issues", issue_cnt, 720);
    chk("t2_infl_le4", infl_max <= MI, 1);
    chk("t2_gen_count", gen_count, CNT_EN ? 1 : 0);

    // paused stepping, long write-back to hit the credit limit
    wb_delay = 6;
    pulse_step();
    cyc(100);
    pulse_step();
    wait_mode(M_WAIT, 4000);
    pulse_frame();
    cyc(20);
    chk("t3_held_idle", busy, 0);
    pulse_step();
    wait_mode(M_WAIT, 4000);
    pulse_frame();
    cyc(2);
    chk("t3_gd", gd_cnt, 3);
    chk("t3_gens", wr720, 3);
    chk("t3_infl_max", infl_max, 4);
    chk("t3_gen_count", gen_count, CNT_EN ? 3 : 0);

    // random ready, write-back overlapping issue
    wb_delay = 1;
    rand_ready = 1'b1;
    pulse_step();
    wait_mode(M_WAIT, 6000);
    rand_ready = 1'b0;
    chk("t4_written_once", wr720, 4);
    chk("t4_coincident", coinc > 0, 1);
    pulse_frame();
    cyc(2);
    chk("t4_bank", bank_disp, 1);

    // stray write-back, load request queued behind a generation
    manual_wb = 1'b1;
    cyc(1);
    manual_wb = 1'b0;
    cyc(2);
    chk("t5_err", err, 1);
    wb_delay = 3;
    pulse_step();
    cyc(50);
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
    wait_mode(M_WAIT, 3000);
    pulse_frame();
    wait_mode(M_LOAD, 10);
    load_grid(1440);
    pulse_frame();
    cyc(2);
    chk("t5_gd", gd_cnt, 5);
    chk("t5_err_sticky", err, 1);
    chk("t5_bank", bank_disp, 1);

    // reset in the middle of a generation
    pulse_step();
    begin
      int n = 0;
      while (m_issued < 400 && n < 2000) begin
        cyc(1);
        n++;
      end
      chk("t6_reach_400", m_issued >= 400, 1);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_bank", bank_disp, 0);
    chk("t6_err", err, 0);
    chk("t6_gen_count", gen_count, 0);
    chk("t6_req_valid", rq_if.row_req_valid, 0);
    pause = 1'b0;
    cyc(10);
    chk("t6_not_loaded", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
